// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // (base + step) mod 3 for base in 0..2 and step in 0..3
  function automatic logic [1:0] wrap3_add(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side signals of the shared memory port arbiter.
interface mem_port_arbiter_if;
  // Requester i holds req[i] until it sees ack[i]. mem_ready is only looked at while
  // mem_valid=1; grant/sel/mem_valid stay stable until the cycle after mem_ready or timeout.
  logic [2:0] req;
  logic       mem_ready;
  logic [1:0] sel;
  logic [2:0] grant;
  logic       mem_valid;
  logic [2:0] ack;
  logic       err;

  modport master (
    output req, mem_ready,
    input  sel, grant, mem_valid, ack, err
  );

  modport slave (
    input  req, mem_ready,
    output sel, grant, mem_valid, ack, err
  );
endinterface

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: nearest set request after 'last' wins.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] idx;

  // Scan farthest-first so the nearest candidate after 'last' overwrites the rest.
  always_comb begin
    win = SEL_REQ0;
    idx = '0;
    for (int k = 3; k >= 1; k--) begin
      idx = wrap3_add(last, 2'(k));
      if (req[idx]) win = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the single memory port shared by three requesters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output arb_state_e          state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       grant_q, grant_d;
  logic             mem_valid_q, mem_valid_d;
  logic [2:0]       ack_q, ack_d;
  logic             err_q, err_d;

  logic [1:0]       win;
  logic             any;

  rr_pick3 u_pick (
    .req  (bus.req),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= SEL_REQ2;
      sel_q       <= SEL_NONE;
      grant_q     <= '0;
      mem_valid_q <= 1'b0;
      ack_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    mem_valid_d = mem_valid_q;
    ack_d       = '0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d     = BUSY;
          grant_d     = onehot3(win);
          sel_d       = win;
          mem_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      BUSY: begin
        // Ready wins over a simultaneous timeout, so err only flags a true abort.
        if (bus.mem_ready || (cnt_q == CNT_LAST)) begin
          state_d     = IDLE;
          ack_d       = grant_q;
          err_d       = !bus.mem_ready;
          last_d      = sel_q;
          grant_d     = '0;
          sel_d       = SEL_NONE;
          mem_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign state_o       = state_q;

endmodule
